dma_burst_writer: RTL
=====================

Name: dma_burst_writer

Overview:
- Parametrised stream-to-SDRAM DMA writer. It accepts a line-scanner data stream and buffers it in an internal FIFO.
- It issues Avalon-MM write bursts into a circular buffer in HPS SDRAM through the FPGA-to-SDRAM port.
- Successor to the fixed 128-bit, single-address DMA path: width, burst length and FIFO depth are generalised, and it adds ring wrap, a wrap IRQ, an overflow flag and clean stop.
- Sits between the pixel pipeline and the soc sdram0 master port. Its cfg and status ports map onto the dma_adr, dma_buf_size and dma_status PIOs.

Parameters:
- DATA_W, 128, stream and Avalon data width in bits (power of 2, >=32).
- ADDR_W, 28, Avalon word address width.
- BCNT_W, 8, burstcount width.
- BURST_LEN, 16, beats per full burst (power of 2, <= 2^(BCNT_W-1)).
- FIFO_DEPTH, 64, FIFO depth in words (power of 2, >= 2*BURST_LEN).

Ports:
- clk  in  1  single clock for all logic (bus_clk domain).
- reset_n  in  1  asynchronous active-low reset.
- s_data  in  DATA_W  stream word.
- s_valid  in  1  stream word valid.
- s_ready  out  1  FIFO can accept; transfer occurs when s_valid&&s_ready.
- cfg_base  in  ADDR_W  ring base, word address.
- cfg_size  in  ADDR_W  ring size in words.
- cfg_start  in  1  one-cycle start pulse.
- cfg_stop  in  1  one-cycle stop pulse.
- m_address  out  ADDR_W  Avalon word address.
- m_burstcount  out  BCNT_W  beats in the current burst.
- m_write  out  1  write request.
- m_writedata  out  DATA_W  write data.
- m_byteenable  out  DATA_W/8  all ones.
- m_waitrequest  in  1  slave stall.
- sts_wr_ptr  out  ADDR_W  word offset of the next burst within the ring.
- sts_wrap_cnt  out  16  number of completed ring passes.
- sts_busy  out  1  engine active.
- sts_overflow  out  1  sticky: input word offered while FIFO full.
- sts_err  out  1  sticky: bad configuration at start.
- irq  out  1  one-cycle pulse on ring wrap.

Behaviour:
- Reset values: all outputs 0, except m_byteenable, which is all ones. State is IDLE and the FIFO is empty.
- FIFO is synchronous and first-word-fall-through.
  - s_ready = running && !full.
  - s_valid while running && full sets sts_overflow; that word is lost.
  - Input is ignored while IDLE.
- Start (cfg_start while IDLE):
  - Latch cfg_base and cfg_size.
  - If size==0 or size%BURST_LEN!=0: set sts_err and stay IDLE.
  - Otherwise: clear sts_overflow, sts_err, sts_wr_ptr and sts_wrap_cnt; set running=1 and go to WAIT.
- cfg_start while not IDLE is ignored.
- WAIT:
  - If fifo_level >= BURST_LEN, go to BURST with beat count = BURST_LEN.
  - Else if stop is pending, go to FLUSH handling (see Optional Feature).
- BURST:
  - m_write=1 on every beat.
  - m_address = base+wr_ptr and m_burstcount are held constant for the whole burst.
  - m_writedata = FIFO head.
  - A beat completes when m_write && !m_waitrequest; the FIFO pops on that same cycle.
  - Last beat done: wr_ptr += beat count. If the result equals size, wr_ptr becomes 0, wrap_cnt increments (wraps at 16 bits) and irq pulses for 1 cycle. Then go to WAIT.
- No idle cycles between beats of a burst. m_write never deasserts mid-burst.
- Next burst address is presented no earlier than 1 cycle after the previous last beat.
- Stop:
  - cfg_stop sets stop_pending and immediately deasserts running, so s_ready goes to 0.
  - A burst in progress always completes.
  - After that, handle the FIFO residue, empty the FIFO, and go to IDLE. Clear sts_busy and stop_pending.
- sts_busy = (state != IDLE).
- Simultaneous cfg_start and cfg_stop in IDLE: stop wins and nothing starts.
- Simultaneous wrap and stop: the wrap is counted and irq still pulses.
- reset_n asserted mid-burst: m_write drops asynchronously and all state is cleared. No burst resume.

Optional Feature:
- Macro DMA_FLUSH_PARTIAL_EN.
- Defined: on stop, a residue of 1..BURST_LEN-1 words is written as one short burst with m_burstcount = residue, then the engine goes IDLE.
  - wr_ptr advances by the residue.
  - If the short burst reaches size exactly, wrap handling applies.
  - If the residue would cross the ring end, it is truncated to size-wr_ptr and the rest is discarded.
- Undefined: the residue is discarded and only full bursts are ever issued.

Test Plan:
- Basic ring: base=0x100, size=32, BURST_LEN=16; push 32 words 0..31, waitrequest=0 -> two bursts at 0x100 and 0x110, data in order, wr_ptr=0, wrap_cnt=1, irq pulses once.
- Stalls: random m_waitrequest 50% while 48 words stream in -> every word written exactly once in order; address and burstcount stable within each burst; 3 bursts total.
- Overflow: hold waitrequest=1 and push 70 words into FIFO_DEPTH=64 -> s_ready drops after 64 words; sts_overflow=1; after release, 64 words are written.
- Bad config: start with size=24 -> sts_err=1, sts_busy=0, no m_write. Then start with size=32 -> sts_err clears.
- Stop with residue: push 21 words then cfg_stop -> one 16-beat burst. With DMA_FLUSH_PARTIAL_EN: a 5-beat burst at base+16 and wr_ptr=21. Without it: wr_ptr=16. Either way sts_busy then reads 0.
- Reset mid-burst: assert reset_n=0 at beat 7 -> m_write=0 immediately; all sts_* read 0 after release.

Source files
------------

// File: rtl/dma_burst_writer.sv
// Stream-to-Avalon DMA writer: FWFT FIFO feeding fixed-length write bursts into a ring buffer.
// Define DMA_FLUSH_PARTIAL_EN to write the FIFO residue on stop as one short burst.
//
// state   | meaning
// IDLE    | engine off, input ignored, waiting for cfg_start
// WAIT    | running, waiting for a full burst in the FIFO (or a pending stop)
// BURST   | issuing write beats, address/burstcount held
// FLUSH   | discarding any FIFO residue, then back to IDLE
module dma_burst_writer #(
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 28,
  parameter int BCNT_W     = 8,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [ADDR_W-1:0]   cfg_base,
  input  logic [ADDR_W-1:0]   cfg_size,
  input  logic                cfg_start,
  input  logic                cfg_stop,
  output logic [ADDR_W-1:0]   m_address,
  output logic [BCNT_W-1:0]   m_burstcount,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  input  logic                m_waitrequest,
  output logic [ADDR_W-1:0]   sts_wr_ptr,
  output logic [15:0]         sts_wrap_cnt,
  output logic                sts_busy,
  output logic                sts_overflow,
  output logic                sts_err,
  output logic                irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] BL_MASK = ADDR_W'(BURST_LEN - 1);
  localparam logic [BCNT_W-1:0] BL_CNT  = BCNT_W'(BURST_LEN);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_FLUSH} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  fifo_wp, fifo_rp;
  logic [LVL_W-1:0]  level;

  logic              running, stop_pending, flush_burst;
  logic [ADDR_W-1:0] base_q, size_q, wr_ptr;
  logic [15:0]       wrap_cnt;
  logic              overflow, err, irq_q;
  logic [BCNT_W-1:0] burst_len, beats_left;

  logic              full, push, pop, beat_done, last_beat;
  logic              start_req, cfg_bad, have_full, partial_go, wraps;
  logic [ADDR_W-1:0] room, lvl_a, residue, ptr_sum;

  assign full       = (level == LVL_W'(FIFO_DEPTH));
  assign push       = s_valid && running && !full;
  assign beat_done  = m_write && !m_waitrequest;
  assign pop        = beat_done;
  assign last_beat  = beat_done && (beats_left == BCNT_W'(1));
  assign start_req  = (state == S_IDLE) && cfg_start && !cfg_stop;
  assign cfg_bad    = (cfg_size == '0) || ((cfg_size & BL_MASK) != '0);
  assign have_full  = (level >= LVL_W'(BURST_LEN));
  assign room       = size_q - wr_ptr;
  assign lvl_a      = ADDR_W'(level);
  // A short flush burst never runs past the ring end; anything beyond is dropped.
  assign residue    = (lvl_a < room) ? lvl_a : room;
  assign ptr_sum    = wr_ptr + ADDR_W'(burst_len);
  assign wraps      = (ptr_sum == size_q);

`ifdef DMA_FLUSH_PARTIAL_EN
  assign partial_go = (level != '0);
`else
  assign partial_go = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_req && !cfg_bad) state_nxt = S_WAIT;
      S_WAIT: begin
        if (have_full)         state_nxt = S_BURST;
        else if (stop_pending) state_nxt = partial_go ? S_BURST : S_FLUSH;
      end
      S_BURST: if (last_beat) state_nxt = flush_burst ? S_FLUSH : S_WAIT;
      S_FLUSH: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    m_write      = (state == S_BURST);
    sts_busy     = (state != S_IDLE);
    m_address    = '0;
    m_burstcount = '0;
    m_writedata  = '0;
    if (m_write) begin
      m_address    = base_q + wr_ptr;
      m_burstcount = burst_len;
      m_writedata  = mem[fifo_rp];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[fifo_wp] <= s_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_wp <= '0;
      fifo_rp <= '0;
      level   <= '0;
    end else if (state == S_FLUSH) begin
      fifo_wp <= '0;
      fifo_rp <= '0;
      level   <= '0;
    end else begin
      if (push) fifo_wp <= fifo_wp + PTR_W'(1);
      if (pop)  fifo_rp <= fifo_rp + PTR_W'(1);
      if (push && !pop)      level <= level + LVL_W'(1);
      else if (pop && !push) level <= level - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      running      <= 1'b0;
      stop_pending <= 1'b0;
      flush_burst  <= 1'b0;
      base_q       <= '0;
      size_q       <= '0;
      wr_ptr       <= '0;
      wrap_cnt     <= '0;
      overflow     <= 1'b0;
      err          <= 1'b0;
      irq_q        <= 1'b0;
      burst_len    <= '0;
      beats_left   <= '0;
    end else begin
      irq_q <= 1'b0;
      if (start_req) begin
        base_q <= cfg_base;
        size_q <= cfg_size;
        if (cfg_bad) begin
          err <= 1'b1;
        end else begin
          err      <= 1'b0;
          overflow <= 1'b0;
          wr_ptr   <= '0;
          wrap_cnt <= '0;
          running  <= 1'b1;
        end
      end
      if (cfg_stop && (state != S_IDLE)) begin
        stop_pending <= 1'b1;
        running      <= 1'b0;
      end
      if (s_valid && running && full) overflow <= 1'b1;
      if ((state == S_WAIT) && (state_nxt == S_BURST)) begin
        burst_len   <= have_full ? BL_CNT : BCNT_W'(residue);
        beats_left  <= have_full ? BL_CNT : BCNT_W'(residue);
        flush_burst <= !have_full;
      end
      if (beat_done) beats_left <= beats_left - BCNT_W'(1);
      if (last_beat) begin
        if (wraps) begin
          wr_ptr   <= '0;
          wrap_cnt <= wrap_cnt + 16'd1;
          irq_q    <= 1'b1;
        end else begin
          wr_ptr <= ptr_sum;
        end
      end
      if (state == S_FLUSH) begin
        stop_pending <= 1'b0;
        running      <= 1'b0;
        flush_burst  <= 1'b0;
      end
    end
  end

  assign s_ready      = running && !full;
  assign m_byteenable = '1;
  assign sts_wr_ptr   = wr_ptr;
  assign sts_wrap_cnt = wrap_cnt;
  assign sts_overflow = overflow;
  assign sts_err      = err;
  assign irq          = irq_q;

endmodule
